aux_memory_writer: RTL and testbench

Writer side of the 32-entry x 16-bit aux display memory that the frame generator reads. Once per frame, on a frame-start pulse, the block snapshots the CPU-visible registers and writes them to aux entries 0x00-0x09. It then fetches two 10-word windows, one from instruction memory and one from data memory, through a shared request/valid read port. It writes those windows to aux entries 0x0A-0x13 and 0x14-0x1D. This keeps the aux memory coherent for one whole displayed frame.

---
 rtl/vga_aux_pkg.sv | 63 ++++++
 rtl/aux_memory_writer_window_fetcher.sv | 96 +++++++++
 rtl/aux_memory_writer.sv | 147 ++++++++++++++
 tb/tb_aux_memory_writer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_aux_pkg.sv
// Shared aux display memory map, writer/fetcher state types and the window clamp.
// The frame generator reads the same map, so both sides stay in agreement.
package vga_aux_pkg;

  localparam int unsigned DATA_WIDTH           = 16;
  localparam int unsigned MEMORY_ADDRESS_WIDTH = 11;
  localparam int unsigned AUX_ADDRESS_WIDTH    = 5;
  localparam int unsigned CPU_ELEMENTS         = 10;
  localparam int unsigned MEMORY_ELEMENTS      = 10;
  localparam int unsigned FINAL_ADDRESS        = (1 << MEMORY_ADDRESS_WIDTH) - 1;
  localparam int unsigned INDEX_WIDTH          = 4;
  localparam int unsigned WINDOW_LEAD          = MEMORY_ELEMENTS / 2 - 1;

  localparam int unsigned AUX_PC         = 0;
  localparam int unsigned AUX_INSTR_IN   = 1;
  localparam int unsigned AUX_DATA_ADDR  = 2;
  localparam int unsigned AUX_DATA_IN    = 3;
  localparam int unsigned AUX_IR         = 4;
  localparam int unsigned AUX_ACC        = 5;
  localparam int unsigned AUX_ALU_A      = 6;
  localparam int unsigned AUX_ALU_B      = 7;
  localparam int unsigned AUX_CLOCK      = 8;
  localparam int unsigned AUX_STATUS     = 9;
  localparam int unsigned AUX_INSTR_BASE = CPU_ELEMENTS;
  localparam int unsigned AUX_DATA_BASE  = CPU_ELEMENTS + MEMORY_ELEMENTS;

  typedef logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WRITE_CPU,
    MEM_REQ,
    MEM_WAIT,
    DONE
  } writer_state_e;

  typedef enum logic [1:0] {
    F_IDLE,
    F_REQ,
    F_WAIT
  } fetch_state_e;

  typedef struct packed {
    logic                         we;
    logic [AUX_ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]        data;
  } aux_wr_t;

  // Centre a window on v, pinned against both ends of the address space.
  function automatic mem_addr_t window_base(input logic [DATA_WIDTH-1:0] v);
    mem_addr_t a;
    a = v[MEMORY_ADDRESS_WIDTH-1:0];
    if (a < MEMORY_ADDRESS_WIDTH'(WINDOW_LEAD + 1)) begin
      return '0;
    end else if (a > MEMORY_ADDRESS_WIDTH'(FINAL_ADDRESS - (WINDOW_LEAD + 1))) begin
      return MEMORY_ADDRESS_WIDTH'(FINAL_ADDRESS - (MEMORY_ELEMENTS - 1));
    end else begin
      return a - MEMORY_ADDRESS_WIDTH'(WINDOW_LEAD);
    end
  endfunction

endpackage

// File: rtl/aux_memory_writer_window_fetcher.sv
// Request/valid engine reading one memory window word by word and handing each
// word to the aux write port; reused for the instruction and data windows.
module window_fetcher
  import vga_aux_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  start_i,
  input  logic                  select_i,
  input  mem_addr_t             base_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  mem_rreq_o,
  output logic                  mem_select_o,
  output mem_addr_t             mem_raddress_o,
  output aux_wr_t               aux_wr_c,
  output logic                  done_c
);

  fetch_state_e           state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;
  mem_addr_t              base_q, base_d;
  mem_addr_t              raddr_q, raddr_d;
  logic                   select_q, select_d;
  logic                   rreq_q, rreq_d;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= F_IDLE;
      idx_q    <= '0;
      base_q   <= '0;
      raddr_q  <= '0;
      select_q <= 1'b0;
      rreq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      raddr_q  <= raddr_d;
      select_q <= select_d;
      rreq_q   <= rreq_d;
    end
  end

  // Request and address stay frozen in F_WAIT; rvalid is only honoured there.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    base_d   = base_q;
    raddr_d  = raddr_q;
    select_d = select_q;
    rreq_d   = rreq_q;
    aux_wr_c = '0;
    done_c   = 1'b0;
    case (state_q)
      F_IDLE: begin
        if (start_i) begin
          base_d   = base_i;
          select_d = select_i;
          idx_d    = '0;
          raddr_d  = base_i;
          rreq_d   = 1'b1;
          state_d  = F_WAIT;
        end
      end
      F_REQ: begin
        raddr_d = base_q + MEMORY_ADDRESS_WIDTH'(idx_q);
        rreq_d  = 1'b1;
        state_d = F_WAIT;
      end
      F_WAIT: begin
        if (mem_rvalid_i) begin
          rreq_d        = 1'b0;
          aux_wr_c.we   = 1'b1;
          aux_wr_c.addr = (select_q ? AUX_ADDRESS_WIDTH'(AUX_DATA_BASE)
                                    : AUX_ADDRESS_WIDTH'(AUX_INSTR_BASE))
                          + AUX_ADDRESS_WIDTH'(idx_q);
          aux_wr_c.data = mem_rdata_i;
          if (idx_q == INDEX_WIDTH'(MEMORY_ELEMENTS - 1)) begin
            done_c  = 1'b1;
            state_d = F_IDLE;
          end else begin
            idx_d   = idx_q + INDEX_WIDTH'(1);
            state_d = F_REQ;
          end
        end
      end
      default: state_d = F_IDLE;
    endcase
  end

  assign mem_rreq_o     = rreq_q;
  assign mem_select_o   = select_q;
  assign mem_raddress_o = raddr_q;

endmodule

// File: rtl/aux_memory_writer.sv
// Per-frame snapshot of CPU registers plus instruction/data memory windows,
// written into the 32 x 16 aux display memory.
module aux_memory_writer
  import vga_aux_pkg::*;
(
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic                            frame_start_in,
  input  logic [DATA_WIDTH-1:0]           pc_in,
  input  logic [DATA_WIDTH-1:0]           instruction_in,
  input  logic [DATA_WIDTH-1:0]           data_address_in,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic [DATA_WIDTH-1:0]           ir_in,
  input  logic [DATA_WIDTH-1:0]           acc_in,
  input  logic [DATA_WIDTH-1:0]           alu_a_in,
  input  logic [DATA_WIDTH-1:0]           alu_b_in,
  input  logic                            cpu_clock_in,
  input  logic                            status_z_in,
  input  logic                            status_n_in,
  output logic                            mem_rreq_out,
  output logic                            mem_select_out,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_raddress_out,
  input  logic                            mem_rvalid_in,
  input  logic [DATA_WIDTH-1:0]           mem_rdata_in,
  output logic                            aux_we_out,
  output logic [AUX_ADDRESS_WIDTH-1:0]    aux_waddress_out,
  output logic [DATA_WIDTH-1:0]           aux_wdata_out,
  output logic                            busy_out,
  output logic                            done_out
);

  writer_state_e          state_q, state_d;
  logic [INDEX_WIDTH-1:0] k_q, k_d;
  logic                   win_q, win_d;
  logic [DATA_WIDTH-1:0]  snap_q [CPU_ELEMENTS];
  logic [DATA_WIDTH-1:0]  snap_d [CPU_ELEMENTS];
  aux_wr_t                aux_q, aux_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   fetch_start_c;
  mem_addr_t              fetch_base_c;
  aux_wr_t                fetch_wr_c;
  logic                   fetch_done_c;

  assign fetch_start_c = (state_q == MEM_REQ);
  assign fetch_base_c  = win_q ? window_base(snap_q[AUX_DATA_ADDR])
                               : window_base(snap_q[AUX_PC]);

  window_fetcher u_fetcher (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .start_i        (fetch_start_c),
    .select_i       (win_q),
    .base_i         (fetch_base_c),
    .mem_rvalid_i   (mem_rvalid_in),
    .mem_rdata_i    (mem_rdata_in),
    .mem_rreq_o     (mem_rreq_out),
    .mem_select_o   (mem_select_out),
    .mem_raddress_o (mem_raddress_out),
    .aux_wr_c       (fetch_wr_c),
    .done_c         (fetch_done_c)
  );

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      k_q     <= '0;
      win_q   <= 1'b0;
      snap_q  <= '{default: '0};
      aux_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      win_q   <= win_d;
      snap_q  <= snap_d;
      aux_q   <= aux_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Frame sequencing; frame_start outside IDLE is deliberately dropped.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    win_d   = win_q;
    snap_d  = snap_q;
    aux_d   = aux_q;
    aux_d.we = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start_in) state_d = CAPTURE;
      end
      CAPTURE: begin
        snap_d[AUX_PC]        = pc_in;
        snap_d[AUX_INSTR_IN]  = instruction_in;
        snap_d[AUX_DATA_ADDR] = data_address_in;
        snap_d[AUX_DATA_IN]   = data_in;
        snap_d[AUX_IR]        = ir_in;
        snap_d[AUX_ACC]       = acc_in;
        snap_d[AUX_ALU_A]     = alu_a_in;
        snap_d[AUX_ALU_B]     = alu_b_in;
        snap_d[AUX_CLOCK]     = DATA_WIDTH'(cpu_clock_in);
        snap_d[AUX_STATUS]    = DATA_WIDTH'({status_z_in, status_n_in});
        k_d     = '0;
        win_d   = 1'b0;
        state_d = WRITE_CPU;
      end
      WRITE_CPU: begin
        aux_d.we   = 1'b1;
        aux_d.addr = AUX_ADDRESS_WIDTH'(k_q);
        aux_d.data = snap_q[k_q];
        if (k_q == INDEX_WIDTH'(CPU_ELEMENTS - 1)) begin
          state_d = MEM_REQ;
        end else begin
          k_d = k_q + INDEX_WIDTH'(1);
        end
      end
      MEM_REQ: state_d = MEM_WAIT;
      MEM_WAIT: begin
        if (fetch_wr_c.we) aux_d = fetch_wr_c;
        if (fetch_done_c) begin
          if (win_q) begin
            state_d = DONE;
          end else begin
            win_d   = 1'b1;
            state_d = MEM_REQ;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign aux_we_out       = aux_q.we;
  assign aux_waddress_out = aux_q.addr;
  assign aux_wdata_out    = aux_q.data;
  assign busy_out         = busy_q;
  assign done_out         = done_q;

endmodule

// File: tb/tb_aux_memory_writer.sv
// Randomised frame bench for aux_memory_writer with a reference aux image,
// a request/valid memory responder and a write-order scoreboard.
module tb_aux_memory_writer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        frame_start_in;
  logic [15:0] pc_in, instruction_in, data_address_in, data_in;
  logic [15:0] ir_in, acc_in, alu_a_in, alu_b_in;
  logic        cpu_clock_in, status_z_in, status_n_in;
  logic        mem_rreq_out, mem_select_out;
  logic [10:0] mem_raddress_out;
  logic        mem_rvalid_in;
  logic [15:0] mem_rdata_in;
  logic        aux_we_out;
  logic [4:0]  aux_waddress_out;
  logic [15:0] aux_wdata_out;
  logic        busy_out, done_out;

  aux_memory_writer dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .frame_start_in   (frame_start_in),
    .pc_in            (pc_in),
    .instruction_in   (instruction_in),
    .data_address_in  (data_address_in),
    .data_in          (data_in),
    .ir_in            (ir_in),
    .acc_in           (acc_in),
    .alu_a_in         (alu_a_in),
    .alu_b_in         (alu_b_in),
    .cpu_clock_in     (cpu_clock_in),
    .status_z_in      (status_z_in),
    .status_n_in      (status_n_in),
    .mem_rreq_out     (mem_rreq_out),
    .mem_select_out   (mem_select_out),
    .mem_raddress_out (mem_raddress_out),
    .mem_rvalid_in    (mem_rvalid_in),
    .mem_rdata_in     (mem_rdata_in),
    .aux_we_out       (aux_we_out),
    .aux_waddress_out (aux_waddress_out),
    .aux_wdata_out    (aux_wdata_out),
    .busy_out         (busy_out),
    .done_out         (done_out)
  );

  always #5 clk_in = ~clk_in;

  logic [15:0] imem [2048];
  logic [15:0] dmem [2048];
  logic [15:0] exp_aux   [32];
  logic [15:0] aux_model [32];
  logic [10:0] exp_addr  [20];
  logic        exp_sel   [20];
  int          wr_n, req_n;
  int          n_tests, n_fail;
  bit          fixed_lat, stray_rv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Window placement rule: centred on v, pinned to [0, 2047].
  function automatic int ref_base(input logic [15:0] v);
    int a;
    a = int'(v) % 2048;
    if (a < 5) return 0;
    if (a > 2047 - 5) return 2047 - 9;
    return a - 4;
  endfunction

  task automatic scramble_cpu();
    pc_in = 16'($urandom); instruction_in = 16'($urandom);
    data_address_in = 16'($urandom); data_in = 16'($urandom);
    ir_in = 16'($urandom); acc_in = 16'($urandom);
    alu_a_in = 16'($urandom); alu_b_in = 16'($urandom);
    cpu_clock_in = 1'($urandom); status_z_in = 1'($urandom); status_n_in = 1'($urandom);
  endtask

  task automatic set_cpu(input logic [15:0] pc, input logic [15:0] da, input logic [15:0] acc,
                         input logic z, input logic nf, input logic ck);
    scramble_cpu();
    pc_in = pc; data_address_in = da; acc_in = acc;
    status_z_in = z; status_n_in = nf; cpu_clock_in = ck;
  endtask

  task automatic build_expect();
    int ib, db;
    ib = ref_base(pc_in);
    db = ref_base(data_address_in);
    exp_aux[0] = pc_in;           exp_aux[1] = instruction_in;
    exp_aux[2] = data_address_in; exp_aux[3] = data_in;
    exp_aux[4] = ir_in;           exp_aux[5] = acc_in;
    exp_aux[6] = alu_a_in;        exp_aux[7] = alu_b_in;
    exp_aux[8] = {15'd0, cpu_clock_in};
    exp_aux[9] = {14'd0, status_z_in, status_n_in};
    for (int i = 0; i < 10; i++) begin
      exp_aux[10 + i] = imem[ib + i];
      exp_addr[i]     = 11'(ib + i);
      exp_sel[i]      = 1'b0;
      exp_aux[20 + i] = dmem[db + i];
      exp_addr[10 + i] = 11'(db + i);
      exp_sel[10 + i]  = 1'b1;
    end
    exp_aux[30] = 16'h0; exp_aux[31] = 16'h0;
    for (int k = 0; k < 32; k++) aux_model[k] = ~exp_aux[k];
    wr_n  = 0;
    req_n = 0;
  endtask

  // Aux write scoreboard: entries must arrive as 0..29 in order with the snapshot/window data.
  always @(negedge clk_in) begin
    if (aux_we_out === 1'b1) begin
      check("aux_order", 32'(aux_waddress_out), 32'(wr_n));
      check("aux_data", 32'(aux_wdata_out), 32'(exp_aux[aux_waddress_out]));
      aux_model[aux_waddress_out] = aux_wdata_out;
      wr_n++;
    end
  end

  // Memory responder: answers 1+delay cycles after seeing rreq, optionally sprays stray rvalid.
  initial begin
    logic [10:0] a;
    logic        s;
    int          d;
    bit          aborted;
    mem_rvalid_in = 1'b0;
    mem_rdata_in  = 16'h0;
    forever begin
      @(negedge clk_in);
      if (rst_n_in !== 1'b1) begin
        mem_rvalid_in = 1'b0;
      end else if (mem_rreq_out !== 1'b1) begin
        if (stray_rv && $urandom_range(0, 2) == 0) begin
          mem_rvalid_in = 1'b1;
          mem_rdata_in  = 16'($urandom);
        end else begin
          mem_rvalid_in = 1'b0;
        end
      end else begin
        mem_rvalid_in = 1'b0;
        a = mem_raddress_out;
        s = mem_select_out;
        if (req_n < 20) begin
          check("rd_addr", 32'(a), 32'(exp_addr[req_n]));
          check("rd_sel", 32'(s), 32'(exp_sel[req_n]));
        end else begin
          check("rd_count", 32'(req_n + 1), 32'd20);
        end
        req_n++;
        d = fixed_lat ? 0 : int'($urandom_range(0, 7));
        aborted = 1'b0;
        for (int j = 0; j <= d && !aborted; j++) begin
          @(negedge clk_in);
          if (rst_n_in !== 1'b1) begin
            aborted = 1'b1;
          end else begin
            check("rreq_hold", 32'(mem_rreq_out), 32'd1);
            check("addr_hold", 32'(mem_raddress_out), 32'(a));
          end
        end
        if (!aborted) begin
          mem_rvalid_in = 1'b1;
          mem_rdata_in  = s ? dmem[a] : imem[a];
          @(negedge clk_in);
          mem_rvalid_in = 1'b0;
        end
      end
    end
  end

  task automatic run_frame(input int exp_lat, input bit chg, input bit stray_fs);
    int n, bad;
    build_expect();
    @(negedge clk_in);
    frame_start_in = 1'b1;
    @(negedge clk_in);
    frame_start_in = 1'b0;
    n = 1;
    check("busy_start", 32'(busy_out), 32'd1);
    while (done_out !== 1'b1 && n < 3000) begin
      if (chg && n == 3) scramble_cpu();
      if (stray_fs && n == 20) frame_start_in = 1'b1;
      if (stray_fs && n == 21) frame_start_in = 1'b0;
      @(negedge clk_in);
      n++;
    end
    check("done_seen", 32'(done_out), 32'd1);
    if (exp_lat > 0) check("latency", 32'(n), 32'(exp_lat));
    @(negedge clk_in);
    check("done_pulse", 32'(done_out), 32'd0);
    check("busy_end", 32'(busy_out), 32'd0);
    check("write_count", 32'(wr_n), 32'd30);
    check("read_count", 32'(req_n), 32'd20);
    bad = 0;
    for (int k = 0; k < 30; k++) if (aux_model[k] !== exp_aux[k]) bad++;
    check("aux_image", 32'(bad), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rreq"}, 32'(mem_rreq_out), 32'd0);
    check({tag, "_sel"}, 32'(mem_select_out), 32'd0);
    check({tag, "_raddr"}, 32'(mem_raddress_out), 32'd0);
    check({tag, "_we"}, 32'(aux_we_out), 32'd0);
    check({tag, "_waddr"}, 32'(aux_waddress_out), 32'd0);
    check({tag, "_wdata"}, 32'(aux_wdata_out), 32'd0);
    check({tag, "_busy"}, 32'(busy_out), 32'd0);
    check({tag, "_done"}, 32'(done_out), 32'd0);
  endtask

  initial begin
    int t;
    n_tests = 0; n_fail = 0; wr_n = 0; req_n = 0;
    fixed_lat = 1'b1; stray_rv = 1'b0;
    rst_n_in = 1'b0;
    frame_start_in = 1'b0;
    scramble_cpu();
    for (int i = 0; i < 2048; i++) begin
      imem[i] = 16'($urandom);
      dmem[i] = 16'($urandom);
    end
    repeat (3) @(negedge clk_in);
    check_outputs_zero("reset");
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);

    // Register snapshot with 1-cycle memory
    set_cpu(16'h0123, 16'h0400, 16'hBEEF, 1'b1, 1'b0, 1'b1);
    run_frame(72, 1'b0, 1'b0);
    check("snap_pc", 32'(aux_model[0]), 32'h0123);
    check("snap_acc", 32'(aux_model[5]), 32'hBEEF);
    check("snap_clk", 32'(aux_model[8]), 32'h0001);
    check("snap_status", 32'(aux_model[9]), 32'h0002);

    // Clamp corners and the middle case
    set_cpu(16'h0003, 16'h0100, 16'($urandom), 1'b0, 1'b1, 1'b0);
    run_frame(72, 1'b0, 1'b0);
    check("low_clamp_first", 32'(exp_addr[0]), 32'h000);
    set_cpu(16'h07FD, 16'h07FA, 16'($urandom), 1'b1, 1'b1, 1'b1);
    run_frame(72, 1'b0, 1'b0);
    set_cpu(16'h07FA, 16'h0005, 16'($urandom), 1'b0, 1'b0, 1'b0);
    run_frame(72, 1'b0, 1'b0);
    set_cpu(16'h0005, 16'hFFFF, 16'($urandom), 1'b1, 1'b0, 1'b0);
    run_frame(72, 1'b0, 1'b0);
    repeat (3) begin
      scramble_cpu();
      run_frame(72, 1'b0, 1'b0);
    end

    // Back-pressure, stray rvalid/frame_start, inputs changing after capture
    fixed_lat = 1'b0; stray_rv = 1'b1;
    scramble_cpu();
    imem[ref_base(pc_in) + 3] = 16'hA5A5;
    dmem[ref_base(data_address_in) + 7] = 16'hA5A5;
    run_frame(0, 1'b1, 1'b1);
    check("bp_a5a5_instr", 32'(aux_model[13]), 32'hA5A5);
    check("bp_a5a5_data", 32'(aux_model[27]), 32'hA5A5);
    repeat (4) begin
      scramble_cpu();
      run_frame(0, 1'b1, 1'b1);
    end

    // Reset in the middle of the data window
    fixed_lat = 1'b1; stray_rv = 1'b0;
    scramble_cpu();
    build_expect();
    @(negedge clk_in);
    frame_start_in = 1'b1;
    @(negedge clk_in);
    frame_start_in = 1'b0;
    t = 0;
    while (wr_n < 24 && t < 500) begin @(negedge clk_in); t++; end
    while (mem_rreq_out !== 1'b1 && t < 500) begin @(negedge clk_in); t++; end
    check("reach_data_i4", 32'(wr_n), 32'd24);
    #2 rst_n_in = 1'b0;
    #1 check_outputs_zero("midreset");
    repeat (3) begin
      @(negedge clk_in);
      check("midreset_no_done", 32'(done_out), 32'd0);
    end
    rst_n_in = 1'b1;
    repeat (2) @(negedge clk_in);
    scramble_cpu();
    run_frame(72, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
